// File: rtl/rgb_to_yuv_pipe.sv
// rgb_to_yuv_pipe
// Three-stage pipelined RGB -> YUV converter, PIXELS lanes per beat,
// BT.601 / BT.709 coefficients chosen per beat, valid/ready on both sides.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   input beat valid
//   in_ready   input beat accepted this cycle (adv && !rst)
//   in_data    per lane {B, G, R}, DATA_WIDTH each, unsigned
//   in_mode    0 = BT.601, 1 = BT.709 for this beat
//   in_user    sideband carried with the beat
//   out_valid  output beat valid
//   out_ready  downstream accepts
//   out_data   per lane {V, U, Y}, DATA_WIDTH each, unsigned
//   out_user   sideband aligned with out_data
//   out_sat    per lane: at least one component was clamped
module rgb_to_yuv_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int PIXELS     = 1,
  parameter int USER_WIDTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [PIXELS*3*DATA_WIDTH-1:0] in_data,
  input  logic                           in_mode,
  input  logic [USER_WIDTH-1:0]          in_user,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [PIXELS*3*DATA_WIDTH-1:0] out_data,
  output logic [USER_WIDTH-1:0]          out_user,
  output logic [PIXELS-1:0]              out_sat
);

  localparam int DW = DATA_WIDTH;
  localparam int LW = 3 * DW;     // bits per lane
  localparam int PW = DW + 18;    // product / sum width
  localparam int SW = DW + 2;     // rounded component width

  typedef logic signed [16:0] coef_t;

  // Row-major: Y row, U row, V row; columns R, G, B.
  localparam coef_t COEF [2][9] = '{
    '{17'sd19595,  17'sd38470,  17'sd7471,
      -17'sd11056, -17'sd21712, 17'sd32768,
      17'sd32768,  -17'sd27440, -17'sd5328},
    '{17'sd13933,  17'sd46871,  17'sd4732,
      -17'sd7509,  -17'sd25259, 17'sd32768,
      17'sd32768,  -17'sd29763, -17'sd3005}
  };

  localparam logic signed [SW:0] OFFS = (SW+1)'(2 ** (DW - 1));
  localparam logic signed [SW:0] MAXV = (SW+1)'(2 ** DW - 1);

  logic v1_q, v2_q, v3_q;
  logic adv;

  logic signed [PW-1:0] p1_d [PIXELS][9];
  logic signed [PW-1:0] p1_q [PIXELS][9];
  logic signed [SW-1:0] s2_d [PIXELS][3];
  logic signed [SW-1:0] s2_q [PIXELS][3];
  logic [PIXELS*LW-1:0] d3_d, d3_q;
  logic [PIXELS-1:0]    sat3_d, sat3_q;
  logic [USER_WIDTH-1:0] u1_q, u2_q, u3_q;

  // The whole pipe moves together; a stalled output freezes every stage,
  // bubbles included.
  assign adv      = !v3_q || out_ready;
  assign in_ready = adv && !rst;

  // S1: nine products per lane. Mode is consumed here, so it need not be
  // stored further down the pipe.
  always_comb begin
    for (int p = 0; p < PIXELS; p++) begin
      for (int row = 0; row < 3; row++) begin
        for (int col = 0; col < 3; col++) begin
          p1_d[p][row*3+col] =
            PW'(signed'({1'b0, in_data[p*LW + col*DW +: DW]})) *
            PW'(COEF[in_mode][row*3+col]);
        end
      end
    end
  end

  // S2: sum, round with +0.5, floor shift by 16. The sum always fits in
  // PW bits, so the top PW-16 bits are the shifted result.
  always_comb begin
    logic signed [PW-1:0] acc;
    acc = '0;
    for (int p = 0; p < PIXELS; p++) begin
      for (int row = 0; row < 3; row++) begin
        acc = p1_q[p][row*3] + p1_q[p][row*3+1] + p1_q[p][row*3+2] +
              PW'(32768);
        s2_d[p][row] = acc[PW-1:16];
      end
    end
  end

  // S3: chroma offset and clamp to the unsigned output range.
  always_comb begin
    logic signed [SW:0] val;
    val    = '0;
    d3_d   = '0;
    sat3_d = '0;
    for (int p = 0; p < PIXELS; p++) begin
      for (int c = 0; c < 3; c++) begin
        val = (SW+1)'(s2_q[p][c]);
        if (c != 0) begin
          val = val + OFFS;
        end
        if (val < 0) begin
          d3_d[p*LW + c*DW +: DW] = '0;
          sat3_d[p] = 1'b1;
        end else if (val > MAXV) begin
          d3_d[p*LW + c*DW +: DW] = {DW{1'b1}};
          sat3_d[p] = 1'b1;
        end else begin
          d3_d[p*LW + c*DW +: DW] = val[DW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      p1_q   <= '{default: '0};
      s2_q   <= '{default: '0};
      d3_q   <= '0;
      sat3_q <= '0;
      u1_q   <= '0;
      u2_q   <= '0;
      u3_q   <= '0;
    end else if (adv) begin
      v1_q   <= in_valid;
      v2_q   <= v1_q;
      v3_q   <= v2_q;
      p1_q   <= p1_d;
      s2_q   <= s2_d;
      d3_q   <= d3_d;
      sat3_q <= sat3_d;
      u1_q   <= in_user;
      u2_q   <= u1_q;
      u3_q   <= u2_q;
    end
  end

  assign out_valid = v3_q;
  assign out_data  = d3_q;
  assign out_user  = u3_q;
  assign out_sat   = sat3_q;

endmodule
